// File: rtl/down_timer_ip.sv
`default_nettype none
// ============================================================================
//  Module   : down_timer_ip
//  Purpose  : Loadable down-counter with IDLE/RUN/PAUSE control, optional
//             auto-reload at terminal count and a registered done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module down_timer_ip #(
   parameter int Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ena_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             reload_i,
   output logic [Width-1:0] q_o,
   output logic             busy_o,
   output logic             paused_o,
   output logic             done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   localparam logic [Width-1:0] c_zero = '0;
   localparam logic [Width-1:0] c_one  = {{(Width-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [Width-1:0] count_q, count_d;
   logic [Width-1:0] reload_q, reload_d;
   logic             done_q, done_d;

   // Terminal count: a qualified tick while the count sits at one.
   logic             tc_w;
   assign tc_w = (count_q == c_one);

   // State, count, reload value and done pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         count_q  <= c_zero;
         reload_q <= c_zero;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic; command priority is load > stop > start > ena.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;

      if (load_i) begin
         // A load aborts any run or pause and re-arms both registers.
         count_d  = load_val_i;
         reload_d = load_val_i;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (stop_i) begin
                  // Nothing to pause; stop also masks a simultaneous start.
                  state_d = IDLE;
               end else if (start_i) begin
                  if (count_q == c_zero) begin
                     // Starting an expired timer reports completion at once.
                     done_d = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end

            RUN: begin
               if (stop_i) begin
                  state_d = PAUSE;
               end else if (start_i) begin
                  // Already running; start outranks the tick, so hold.
                  state_d = RUN;
               end else if (ena_i) begin
                  if (tc_w) begin
                     done_d = 1'b1;
                     if (reload_i && (reload_q != c_zero)) begin
                        count_d = reload_q;
                     end else begin
                        count_d = c_zero;
                        state_d = IDLE;
                     end
                  end else if (count_q != c_zero) begin
                     // Guarded so the count can never wrap below zero.
                     count_d = count_q - c_one;
                  end
               end
            end

            PAUSE: begin
               if (stop_i) begin
                  state_d = PAUSE;
               end else if (start_i) begin
                  state_d = RUN;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers; no input-to-output path.
   assign q_o      = count_q;
   assign busy_o   = (state_q == RUN);
   assign paused_o = (state_q == PAUSE);
   assign done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_down_timer_ip.sv
`default_nettype none
// ============================================================================
//  Module   : tb_down_timer_ip
//  Purpose  : Self-checking bench for down_timer_ip (Width = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_down_timer_ip;

   logic       clk_i;
   logic       rst_ni;
   logic       ena_i;
   logic       load_i;
   logic [7:0] load_val_i;
   logic       start_i;
   logic       stop_i;
   logic       reload_i;
   logic [7:0] q_o;
   logic       busy_o;
   logic       paused_o;
   logic       done_o;

   down_timer_ip #(.Width(8)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .ena_i      (ena_i),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .reload_i   (reload_i),
      .q_o        (q_o),
      .busy_o     (busy_o),
      .paused_o   (paused_o),
      .done_o     (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       load;
      logic [7:0] val;
      logic       start;
      logic       stop;
      logic       reload;
      logic       ena;
      logic [7:0] q;
      logic       busy;
      logic       paused;
      logic       done;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic ld, logic [7:0] v, logic st, logic sp,
                               logic rl, logic en, logic [7:0] q,
                               logic b, logic p, logic d);
      vec_t r;
      r.load = ld; r.val = v; r.start = st; r.stop = sp; r.reload = rl;
      r.ena = en; r.q = q; r.busy = b; r.paused = p; r.done = d;
      return r;
   endfunction

   task automatic cmp_outputs(string name, logic [7:0] eq, logic eb,
                              logic ep, logic ed);
      checks++;
      if (q_o !== eq || busy_o !== eb || paused_o !== ep || done_o !== ed) begin
         errors++;
         $display("FAIL %s: got q=%0d busy=%b paused=%b done=%b, expected q=%0d busy=%b paused=%b done=%b",
                  name, q_o, busy_o, paused_o, done_o, eq, eb, ep, ed);
      end
   endtask

   // Drive one vector, queue its expectation, and compare after the edge.
   task automatic apply(vec_t v, string name);
      vec_t e;
      load_i = v.load; load_val_i = v.val; start_i = v.start;
      stop_i = v.stop; reload_i = v.reload; ena_i = v.ena;
      sb.push_back(v);
      @(posedge clk_i);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         cmp_outputs(name, e.q, e.busy, e.paused, e.done);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      // Fields: load, val, start, stop, reload, ena | q, busy, paused, done
      // Plain count to zero from 3.
      tbl.push_back(mk(1, 8'd3, 0, 0, 0, 0, 8'd3, 0, 0, 0));
      tbl.push_back(mk(0, 8'd0, 1, 0, 0, 1, 8'd3, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd2, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd1, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 1));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 0));
      // Auto-reload from 2.
      tbl.push_back(mk(1, 8'd2, 0, 0, 1, 0, 8'd2, 0, 0, 0));
      tbl.push_back(mk(0, 8'd0, 1, 0, 1, 1, 8'd2, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd2, 1, 0, 1));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd2, 1, 0, 1));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd1, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 1, 1, 0, 8'd1, 0, 1, 0));
      tbl.push_back(mk(1, 8'd5, 0, 0, 0, 0, 8'd5, 0, 0, 0));
      // Pause and resume from 5.
      tbl.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd5, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd4, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd3, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 1, 0, 1, 8'd3, 0, 1, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd3, 0, 1, 0));
      tbl.push_back(mk(0, 8'd0, 0, 1, 0, 0, 8'd3, 0, 1, 0));
      tbl.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd3, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd2, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd1, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 1));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0));
      // Start with zero count, then load beating start.
      tbl.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd0, 0, 0, 1));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0));
      tbl.push_back(mk(1, 8'd7, 1, 0, 0, 0, 8'd7, 0, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd7, 0, 0, 0));
      // Reload of one: done every tick while reloading.
      tbl.push_back(mk(1, 8'd1, 0, 0, 0, 0, 8'd1, 0, 0, 0));
      tbl.push_back(mk(0, 8'd0, 1, 0, 1, 0, 8'd1, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, 1));
      tbl.push_back(mk(0, 8'd0, 0, 0, 1, 1, 8'd1, 1, 0, 1));
      tbl.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 1));
      // Stop outranks start in IDLE and RUN; load aborts PAUSE.
      tbl.push_back(mk(0, 8'd0, 1, 1, 0, 0, 8'd0, 0, 0, 0));
      tbl.push_back(mk(1, 8'd4, 0, 0, 0, 0, 8'd4, 0, 0, 0));
      tbl.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd4, 1, 0, 0));
      tbl.push_back(mk(0, 8'd0, 1, 1, 0, 1, 8'd4, 0, 1, 0));
      tbl.push_back(mk(1, 8'd9, 1, 0, 0, 1, 8'd9, 0, 0, 0));

      rst_ni = 1'b0; ena_i = 0; load_i = 0; load_val_i = 0;
      start_i = 0; stop_i = 0; reload_i = 0;
      #1;
      cmp_outputs("reset_state", 8'd0, 0, 0, 0);
      @(posedge clk_i);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Long count from 0xFF, aborted by an asynchronous reset.
      apply(mk(1, 8'hFF, 0, 0, 0, 0, 8'hFF, 0, 0, 0), "ff_load");
      apply(mk(0, 8'h00, 1, 0, 0, 0, 8'hFF, 1, 0, 0), "ff_start");
      for (int i = 1; i <= 10; i++) begin
         apply(mk(0, 8'h00, 0, 0, 0, 1, 8'hFF - 8'(i), 1, 0, 0),
               $sformatf("ff_tick%0d", i));
      end
      #2;
      rst_ni = 1'b0;
      #1;
      cmp_outputs("async_reset_now", 8'd0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk_i);
         #1;
         cmp_outputs($sformatf("reset_held%0d", i), 8'd0, 0, 0, 0);
      end
      #3;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      apply(mk(1, 8'd1, 0, 0, 0, 1, 8'd1, 0, 0, 0), "post_rst_load");
      apply(mk(0, 8'd0, 1, 0, 0, 1, 8'd1, 1, 0, 0), "post_rst_start");
      apply(mk(0, 8'd0, 0, 0, 0, 1, 8'd0, 0, 0, 1), "post_rst_tick");
      apply(mk(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0), "post_rst_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
